// File: rtl/aes_host_pkg.sv
// Shared types and sizing for the byte-serial AES host.
package aes_host_pkg;
    localparam int NUM_BYTES       = 16;
    localparam int BYTE_W          = 8;
    localparam int DATA_W          = NUM_BYTES * BYTE_W;
    localparam int TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LOAD,
        WAIT_CT,
        COLLECT,
        DONE
    } state_t;
endpackage

// File: rtl/aes_byte_shifter.sv
// 128-bit register: parallel load, or shift one byte in at the LSB end while
// the MSB byte (byte 1) leaves first.
module aes_byte_shifter
    import aes_host_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [DATA_W-1:0] data_o
);
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= load_data_i;
        end else if (shift_i) begin
            data_q <= {data_q[DATA_W-BYTE_W-1:0], byte_i};
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/aes_byte_host.sv
// Feeds a 16-byte plaintext/key pair to a byte-serial AES core and collects
// the 16 ciphertext bytes it returns, with a per-byte watchdog.
module aes_byte_host
    import aes_host_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] pt_in,
    input  logic [DATA_W-1:0] key_in,
    output logic              aes_valid,
    output logic [BYTE_W-1:0] aes_pt,
    output logic [BYTE_W-1:0] aes_key,
    input  logic              aes_ready,
    input  logic              aes_ct_valid,
    input  logic [BYTE_W-1:0] aes_ct,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] ct_out
);
    localparam int          WD_W     = $clog2(TIMEOUT) + 1;
    localparam logic [4:0]  LAST_IDX = 5'(NUM_BYTES - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t            state_q;
    logic [4:0]        byte_cnt_q;
    logic [WD_W-1:0]   wdog_q;
    logic              aes_valid_q;
    logic [BYTE_W-1:0] aes_pt_q;
    logic [BYTE_W-1:0] aes_key_q;
    logic              done_q;
    logic              err_q;

    logic [DATA_W-1:0] pt_data;
    logic [DATA_W-1:0] key_data;
    logic [DATA_W-1:0] ct_data;
    logic              accept;
    logic              src_shift;
    logic              ct_capture;
    logic              unused_src_bits;

    assign accept     = (state_q == IDLE) && start;
    // Byte 1 is copied out on the ARM->LOAD edge, so the source shifts then
    // and on every LOAD cycle except the one presenting byte 16.
    assign src_shift  = ((state_q == ARM) && aes_ready) ||
                        ((state_q == LOAD) && (byte_cnt_q != LAST_IDX));
    assign ct_capture = ((state_q == WAIT_CT) || (state_q == COLLECT)) && aes_ct_valid;

    aes_byte_shifter u_pt_shifter (
        .clk         (clk),
        .rst_n       (reset),
        .load_i      (accept),
        .load_data_i (pt_in),
        .shift_i     (src_shift),
        .byte_i      ('0),
        .data_o      (pt_data)
    );

    aes_byte_shifter u_key_shifter (
        .clk         (clk),
        .rst_n       (reset),
        .load_i      (accept),
        .load_data_i (key_in),
        .shift_i     (src_shift),
        .byte_i      ('0),
        .data_o      (key_data)
    );

    aes_byte_shifter u_ct_shifter (
        .clk         (clk),
        .rst_n       (reset),
        .load_i      (accept),
        .load_data_i ('0),
        .shift_i     (ct_capture),
        .byte_i      (aes_ct),
        .data_o      (ct_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            wdog_q      <= '0;
            aes_valid_q <= 1'b0;
            aes_pt_q    <= '0;
            aes_key_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= ARM;
                        byte_cnt_q <= '0;
                    end
                end
                ARM: begin
                    if (aes_ready) begin
                        state_q     <= LOAD;
                        aes_valid_q <= 1'b1;
                        aes_pt_q    <= pt_data[DATA_W-1 -: BYTE_W];
                        aes_key_q   <= key_data[DATA_W-1 -: BYTE_W];
                        byte_cnt_q  <= '0;
                    end
                end
                LOAD: begin
                    if (byte_cnt_q == LAST_IDX) begin
                        state_q     <= WAIT_CT;
                        aes_valid_q <= 1'b0;
                        aes_pt_q    <= '0;
                        aes_key_q   <= '0;
                        byte_cnt_q  <= '0;
                        wdog_q      <= '0;
                    end else begin
                        aes_pt_q   <= pt_data[DATA_W-1 -: BYTE_W];
                        aes_key_q  <= key_data[DATA_W-1 -: BYTE_W];
                        byte_cnt_q <= byte_cnt_q + 5'd1;
                    end
                end
                WAIT_CT, COLLECT: begin
                    if (aes_ct_valid) begin
                        byte_cnt_q <= byte_cnt_q + 5'd1;
                        wdog_q     <= '0;
                        if (byte_cnt_q == LAST_IDX) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end else if (wdog_q == WD_LAST) begin
                        state_q    <= IDLE;
                        err_q      <= 1'b1;
                        byte_cnt_q <= '0;
                        wdog_q     <= '0;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Only the MSB byte of the plaintext/key shifters is ever observed.
    assign unused_src_bits = ^{pt_data[DATA_W-BYTE_W-1:0], key_data[DATA_W-BYTE_W-1:0]};

    assign aes_valid = aes_valid_q;
    assign aes_pt    = aes_pt_q;
    assign aes_key   = aes_key_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign ct_out    = ct_data;
endmodule

// File: tb/tb_aes_byte_host.sv
// Directed bench for aes_byte_host: the bench plays the AES core, feeding
// known ciphertext bytes and checking load sequence, result, timeout and reset.
module tb_aes_byte_host;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [127:0] pt_in = '0;
    logic [127:0] key_in = '0;
    logic         aes_valid;
    logic [7:0]   aes_pt;
    logic [7:0]   aes_key;
    logic         aes_ready = 1'b0;
    logic         aes_ct_valid = 1'b0;
    logic [7:0]   aes_ct = '0;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] ct_out;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2      = 128'hdeadbeef0badf00dcafebabe13572468;
    localparam logic [127:0] KEY2     = 128'h8899aabbccddeeff0011223344556677;
    localparam logic [127:0] CT2      = 128'h0123456789abcdeffedcba9876543210;

    aes_byte_host #(.TIMEOUT(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pt_in        (pt_in),
        .key_in       (key_in),
        .aes_valid    (aes_valid),
        .aes_pt       (aes_pt),
        .aes_key      (aes_key),
        .aes_ready    (aes_ready),
        .aes_ct_valid (aes_ct_valid),
        .aes_ct       (aes_ct),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .ct_out       (ct_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [127:0] pt, input logic [127:0] key);
        @(negedge clk);
        pt_in  = pt;
        key_in = key;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic run_load(input string tag, input logic [127:0] exp_pt, input logic [127:0] exp_key);
        int w = 0;
        int vcnt = 0;
        logic [127:0] got_pt = '0;
        logic [127:0] got_key = '0;
        while (!aes_valid && w < 64) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_valid_seen"}, 128'(aes_valid), 128'd1);
        for (int k = 0; k < 16; k++) begin
            if (aes_valid) vcnt++;
            got_pt  = {got_pt[119:0], aes_pt};
            got_key = {got_key[119:0], aes_key};
            if (k == 0) aes_ready = 1'b0;
            @(negedge clk);
        end
        check({tag, "_pt_seq"}, got_pt, exp_pt);
        check({tag, "_key_seq"}, got_key, exp_key);
        check({tag, "_valid_cycles"}, 128'(vcnt), 128'd16);
        check({tag, "_idle_bus"}, {111'd0, aes_valid, aes_pt, aes_key}, 128'd0);
    endtask

    task automatic feed_ct(input logic [127:0] ct, input int first, input int last,
                           input int gap, output bit early);
        early = 1'b0;
        for (int i = first; i < last; i++) begin
            aes_ct       = ct[127-8*i -: 8];
            aes_ct_valid = 1'b1;
            @(negedge clk);
            aes_ct_valid = 1'b0;
            aes_ct       = '0;
            if (i < 15 && done) early = 1'b1;
            if (i < last - 1) begin
                repeat (gap) begin
                    @(negedge clk);
                    if (done) early = 1'b1;
                end
            end
        end
    endtask

    task automatic finish_job(input string tag, input logic [127:0] exp_ct);
        check({tag, "_done"}, 128'(done), 128'd1);
        check({tag, "_ct_out"}, ct_out, exp_ct);
        @(negedge clk);
        check({tag, "_after_done"}, {126'd0, done, busy}, 128'd0);
    endtask

    initial begin
        bit early;
        bit bad;
        int n;

        // Reset state
        #2 reset = 1'b0;
        #1;
        check("reset_outputs", {107'd0, aes_valid, aes_pt, aes_key, busy, done, err}, 128'd0);
        check("reset_ct_out", ct_out, 128'd0);
        @(negedge clk);
        reset = 1'b1;

        // FIPS-197 vector, back-to-back ciphertext bytes
        aes_ready = 1'b1;
        start_job(FIPS_PT, FIPS_KEY);
        check("fips_busy", 128'(busy), 128'd1);
        run_load("fips", FIPS_PT, FIPS_KEY);
        feed_ct(FIPS_CT, 0, 16, 0, early);
        check("fips_no_early_done", 128'(early), 128'd0);
        finish_job("fips", FIPS_CT);

        // aes_ready held low for 20 cycles, then 3-cycle gaps between CT bytes
        aes_ready = 1'b0;
        start_job(PT2, KEY2);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (aes_valid || !busy) bad = 1'b1;
        end
        check("ready_low_hold", 128'(bad), 128'd0);
        aes_ready = 1'b1;
        @(negedge clk);
        check("ready_rise_valid", 128'(aes_valid), 128'd1);
        run_load("gap", PT2, KEY2);
        feed_ct(CT2, 0, 16, 3, early);
        check("gap_no_early_done", 128'(early), 128'd0);
        finish_job("gap", CT2);

        // Timeout: five bytes then silence
        aes_ready = 1'b1;
        start_job(FIPS_PT, FIPS_KEY);
        run_load("to", FIPS_PT, FIPS_KEY);
        feed_ct(FIPS_CT, 0, 5, 0, early);
        n = 0;
        while (!err && n < 40) begin
            @(negedge clk);
            n++;
            if (done) early = 1'b1;
        end
        check("to_err_delay", 128'(n), 128'd32);
        check("to_idle_at_err", {126'd0, busy, early}, 128'd0);
        @(negedge clk);
        check("to_err_one_cycle", 128'(err), 128'd0);

        // Recovery job after timeout
        aes_ready = 1'b1;
        start_job(PT2, KEY2);
        run_load("rec", PT2, KEY2);
        feed_ct(FIPS_CT, 0, 16, 1, early);
        check("rec_no_early_done", 128'(early), 128'd0);
        finish_job("rec", FIPS_CT);

        // Reset asserted while byte 7 is on the bus
        aes_ready = 1'b1;
        start_job(FIPS_PT, FIPS_KEY);
        n = 0;
        while (!aes_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        check("rst_byte7", {112'd0, aes_valid, aes_pt, aes_key[6:0]}, {112'd0, 1'b1, 8'h66, 7'h06});
        reset = 1'b0;
        #1;
        check("rst_outputs", {107'd0, aes_valid, aes_pt, aes_key, busy, done, err}, 128'd0);
        check("rst_ct_out", ct_out, 128'd0);
        @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || err || busy) bad = 1'b1;
        end
        check("rst_no_pulse", 128'(bad), 128'd0);

        // Start pulsed during COLLECT must be ignored
        aes_ready = 1'b1;
        start_job(FIPS_PT, FIPS_KEY);
        run_load("col", FIPS_PT, FIPS_KEY);
        feed_ct(CT2, 0, 8, 0, early);
        pt_in = PT2;
        key_in = KEY2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("col_still_busy", 128'(busy), 128'd1);
        feed_ct(CT2, 8, 16, 0, early);
        check("col_no_early_done", 128'(early), 128'd0);
        finish_job("col", CT2);
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy || aes_valid) bad = 1'b1;
        end
        check("col_start_ignored", 128'(bad), 128'd0);

        // Spurious ciphertext strobes in IDLE
        aes_ct       = 8'haa;
        aes_ct_valid = 1'b1;
        repeat (3) @(negedge clk);
        aes_ct_valid = 1'b0;
        aes_ct       = '0;
        @(negedge clk);
        check("idle_ct_ignored", ct_out, CT2);
        check("idle_quiet", {125'd0, busy, done, err}, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
